// File: rtl/gpio_pad_ctrl.sv
// GPIO bank controller: register file for pad o/oe/ie, synchronized and filtered inputs,
// rise/fall pending bits and irq. Define GPIO_PAD_CTRL_DEBOUNCE_EN to build the debounce filter.
module gpio_pad_ctrl #(
  parameter int WIDTH          = 8,
  parameter int DEBOUNCE_W     = 4,
  parameter int DEBOUNCE_RESET = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [WIDTH-1:0] cell_o,
  output logic [WIDTH-1:0] cell_oe,
  output logic [WIDTH-1:0] cell_ie,
  input  logic [WIDTH-1:0] cell_i,
  output logic             irq
);

  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_rdata;
  logic [WIDTH-1:0] r_out, r_oe, r_ie, r_irq_en;
  logic [WIDTH-1:0] r_rise, r_fall;
  logic [WIDTH-1:0] r_sync1, r_sync2, r_stable;

  logic             w_accept, w_wr;
  logic [WIDTH-1:0] w_rdata, w_debounce_rd, w_stable_d;
  logic [WIDTH-1:0] w_rise_set, w_fall_set, w_rise_clr, w_fall_clr;

  // Only narrow-or-equal debounce thresholds are supported.
  if (DEBOUNCE_W > WIDTH || DEBOUNCE_RESET < 0) begin : g_unsupported_cfg
  end

  assign req_ready = !r_resp_valid || resp_ready;
  assign w_accept  = req_valid && req_ready;
  assign w_wr      = w_accept && req_write;

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] r_debounce;
  logic [DEBOUNCE_W-1:0] r_cnt   [WIDTH];
  logic [DEBOUNCE_W-1:0] w_cnt_d [WIDTH];

  // A mismatch must persist past the threshold before the stable bit follows sync2.
  always_comb begin
    w_stable_d = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_d[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] >= r_debounce) begin
          w_stable_d[i] = r_sync2[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_debounce <= DEBOUNCE_W'(DEBOUNCE_RESET);
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      if (w_wr && req_addr == 3'd7) begin
        r_debounce <= req_wdata[DEBOUNCE_W-1:0];
      end
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign w_debounce_rd = WIDTH'(r_debounce);
`else
  assign w_stable_d    = r_sync2;
  assign w_debounce_rd = '0;
`endif

  assign w_rise_set = w_stable_d & ~r_stable;
  assign w_fall_set = ~w_stable_d & r_stable;
  assign w_rise_clr = (w_wr && req_addr == 3'd4) ? req_wdata : '0;
  assign w_fall_clr = (w_wr && req_addr == 3'd5) ? req_wdata : '0;

  always_comb begin
    w_rdata = '0;
    case (req_addr)
      3'd0: w_rdata = r_out;
      3'd1: w_rdata = r_oe;
      3'd2: w_rdata = r_ie;
      3'd3: w_rdata = r_stable;
      3'd4: w_rdata = r_rise;
      3'd5: w_rdata = r_fall;
      3'd6: w_rdata = r_irq_en;
      3'd7: w_rdata = w_debounce_rd;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out    <= '0;
      r_oe     <= '0;
      r_ie     <= '0;
      r_irq_en <= '0;
    end else if (w_wr) begin
      case (req_addr)
        3'd0: r_out    <= req_wdata;
        3'd1: r_oe     <= req_wdata;
        3'd2: r_ie     <= req_wdata;
        3'd6: r_irq_en <= req_wdata;
        default: ;
      endcase
    end
  end

  // New edges take priority over a same-cycle W1C.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
    end else begin
      r_sync1  <= cell_i;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_d;
      r_rise   <= (r_rise & ~w_rise_clr) | w_rise_set;
      r_fall   <= (r_fall & ~w_fall_clr) | w_fall_set;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_rdata <= req_write ? '0 : w_rdata;
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign cell_o     = r_out;
  assign cell_oe    = r_oe;
  assign cell_ie    = r_ie;
  assign irq        = |((r_rise | r_fall) & r_irq_en);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl: driver pushes expected read data, monitor pops on handshake.
// Expectations follow GPIO_PAD_CTRL_DEBOUNCE_EN when it is defined for the build.
module tb_gpio_pad_ctrl;

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  localparam int          LAT        = 5;
  localparam logic [7:0]  DB_RST_EXP = 8'h02;
  localparam logic [7:0]  DB_EXP     = 8'h03;
  localparam logic [7:0]  PULSE_RISE = 8'h01;
  localparam logic [7:0]  PULSE_FALL = 8'h00;
`else
  localparam int          LAT        = 2;
  localparam logic [7:0]  DB_RST_EXP = 8'h00;
  localparam logic [7:0]  DB_EXP     = 8'h00;
  localparam logic [7:0]  PULSE_RISE = 8'h03;
  localparam logic [7:0]  PULSE_FALL = 8'h02;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_rdata;
  logic [7:0] cell_o, cell_oe, cell_ie, cell_i;
  logic       irq;
  logic [7:0] pad;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [7:0] sb[$];

  gpio_pad_ctrl #(
    .WIDTH         (8),
    .DEBOUNCE_W    (4),
    .DEBOUNCE_RESET(2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .cell_o    (cell_o),
    .cell_oe   (cell_oe),
    .cell_ie   (cell_ie),
    .cell_i    (cell_i),
    .irq       (irq)
  );

  // The pad cell forces its input low while input enable is off.
  assign cell_i = pad & cell_ie;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (!reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL resp_unexpected: got response 0x%0h, expected none", resp_rdata);
      end else begin
        chk("resp_rdata", {24'h0, resp_rdata}, {24'h0, sb.pop_front()});
      end
    end
  end

  task automatic bus(input logic w, input logic [2:0] a, input logic [7:0] d,
                     input logic [7:0] exp, output int acc);
    int n = 0;
    acc       = -1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (acc < 0 && n < 20) begin
      @(negedge clock);
      if (req_ready) begin
        sb.push_back(w ? 8'h00 : exp);
        @(posedge clock);
        #1;
        acc = cyc;
      end else begin
        @(posedge clock);
        #1;
        n++;
      end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      n_checks++;
      $display("FAIL req_timeout: got no accept on addr %0d, expected accept within 20 cycles", a);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    int acc;
    bus(1'b1, a, d, 8'h00, acc);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp);
    int acc;
    bus(1'b0, a, 8'h00, exp, acc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, c0;
    logic [7:0] exp_rst [8];
    exp_rst = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, DB_RST_EXP};
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    pad        = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle(1);

    chk("rst_cell_o", cell_o, 0);
    chk("rst_cell_oe", cell_oe, 0);
    chk("rst_cell_ie", cell_ie, 0);
    chk("rst_irq", irq, 0);
    chk("rst_resp_valid", resp_valid, 0);
    for (int a = 0; a < 8; a++) rd(a[2:0], exp_rst[a]);

    // Back-to-back writes with resp_ready held high.
    bus(1'b1, 3'd0, 8'hA5, 8'h00, acc1);
    chk("cell_o_after_write", cell_o, 8'hA5);
    bus(1'b1, 3'd1, 8'h0F, 8'h00, acc2);
    chk("cell_oe_after_write", cell_oe, 8'h0F);
    chk("b2b_accept_gap", acc2 - acc1, 1);
    idle(2);

    // Stalled response holds and blocks further requests.
    resp_ready = 1'b0;
    rd(3'd0, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_rdata", resp_rdata, 8'hA5);
      chk("stall_req_ready", req_ready, 0);
    end
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    c0 = cyc;
    bus(1'b1, 3'd6, 8'h01, 8'h00, acc1);
    chk("unstall_accept_cycle", acc1, c0 + 1);

    wr(3'd2, 8'hFF);
    wr(3'd7, 8'h03);
    rd(3'd7, DB_EXP);
    rd(3'd2, 8'hFF);
    idle(3);
    chk("irq_idle", irq, 0);

    // Rising input on bit 0: irq follows the filtered edge.
    pad[0] = 1'b1;
    for (int e = 0; e <= LAT; e++) begin
      @(posedge clock);
      #1;
      if (e == LAT - 1) chk("irq_before_edge", irq, 0);
      if (e == LAT) chk("irq_after_edge", irq, 1);
    end
    rd(3'd3, 8'h01);
    rd(3'd4, 8'h01);
    rd(3'd5, 8'h00);

    // Three-cycle pulse on bit 1.
    pad[1] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    pad[1] = 1'b0;
    idle(10);
    rd(3'd4, PULSE_RISE);
    rd(3'd5, PULSE_FALL);
    wr(3'd4, 8'h02);
    wr(3'd5, 8'h02);

    // Fall on bit 0, then a rise that lands on the same edge as a W1C of RISE_PEND.
    idle(1);
    pad[0] = 1'b0;
    idle(LAT + 3);
    rd(3'd5, 8'h01);
    idle(2);
    pad[0] = 1'b1;
    repeat (LAT) @(posedge clock);
    #1;
    wr(3'd4, 8'h01);
    rd(3'd4, 8'h01);
    wr(3'd4, 8'h01);
    rd(3'd4, 8'h00);
    chk("irq_fall_still_pending", irq, 1);
    wr(3'd5, 8'h01);
    chk("irq_cleared", irq, 0);

    // Gating the input while high reads as a fall.
    wr(3'd2, 8'hFE);
    idle(LAT + 3);
    rd(3'd5, 8'h01);
    rd(3'd3, 8'h00);
    chk("irq_ie_fall", irq, 1);
    idle(2);

    // Reset with a held response and a counter mid-flight.
    resp_ready = 1'b0;
    pad[2]     = 1'b1;
    rd(3'd0, 8'hA5);
    @(posedge clock);
    #3;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_resp_rdata", resp_rdata, 0);
    chk("mid_rst_cell_o", cell_o, 0);
    chk("mid_rst_cell_oe", cell_oe, 0);
    chk("mid_rst_cell_ie", cell_ie, 0);
    chk("mid_rst_irq", irq, 0);
    @(posedge clock);
    #2;
    reset      = 1'b0;
    resp_ready = 1'b1;
    idle(5);
    chk("post_rst_no_resp", resp_valid, 0);
    rd(3'd7, DB_RST_EXP);
    rd(3'd4, 8'h00);
    idle(3);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Core-side controller for a bank of generic digital GPIO pad cells. It drives each cell's output value, output enable and input enable from software-visible registers. It samples each cell's input through a two-flop synchronizer and an optional per-bit debounce filter, then records rising and falling edges as interrupt pending bits. It sits between the SoC register bus and the pad ring, one instance per GPIO bank.

## Interface
Parameters:
- WIDTH, 8, number of GPIO bits in the bank.
- DEBOUNCE_W, 4, width of the debounce threshold register and of each per-bit counter (DEBOUNCE_W <= WIDTH).
- DEBOUNCE_RESET, 0, reset value of the debounce threshold.

Ports. One clock; reset is asynchronous and active-high.
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- req_valid  input  1  register request present.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  3  register index.
- req_wdata  input  WIDTH  write data.
- resp_valid  output  1  response present.
- resp_ready  input  1  response consumed when resp_valid && resp_ready.
- resp_rdata  output  WIDTH  read data; 0 for write responses.
- cell_o  output  WIDTH  to pad cell o.
- cell_oe  output  WIDTH  to pad cell oe.
- cell_ie  output  WIDTH  to pad cell ie.
- cell_i  input  WIDTH  from pad cell i; asynchronous to clock.
- irq  output  1  OR of (RISE_PEND | FALL_PEND) & IRQ_EN.

## Operation
- Register map:
  - 0 OUT (RW, drives cell_o)
  - 1 OE (RW, drives cell_oe)
  - 2 IE (RW, drives cell_ie)
  - 3 IN (RO, filtered input; writes ignored)
  - 4 RISE_PEND (W1C)
  - 5 FALL_PEND (W1C)
  - 6 IRQ_EN (RW)
  - 7 DEBOUNCE (RW, bits [DEBOUNCE_W-1:0]; reads zero-extended)
- Handshake:
  - req_ready = !resp_valid || resp_ready.
  - Each accepted request produces exactly one response on the next cycle.
  - resp_valid and resp_rdata hold stable until the response is consumed.
  - Back-to-back requests complete at one per cycle while resp_ready stays high.
- Register effects:
  - Write effects take place at the accepting edge.
  - A read returns the register value before that edge's updates. A W1C read returns bits before any same-cycle clear.
- Input path, per bit:
  - Synchronizer: sync1 <= cell_i, then sync2 <= sync1.
  - Filter state: a stable bit plus a DEBOUNCE_W-bit counter.
  - If sync2 == stable: counter <= 0.
  - Else if counter >= DEBOUNCE: stable <= sync2 and counter <= 0.
  - Else: counter <= counter + 1.
  - A glitch that returns to the stable value before the threshold resets the counter and produces no edge.
- Edges:
  - stable 0->1 sets RISE_PEND; stable 1->0 sets FALL_PEND, in the same edge as the stable update.
  - If a W1C clear and a new edge hit the same bit in the same cycle, set wins.
- A DEBOUNCE write mid-count takes effect immediately. A counter already at or above the new value qualifies on the next mismatch cycle.
- cell_i reads 0 when IE=0, because the cell forces it. The filter processes that 0 normally, so clearing IE on a high input produces a fall edge.
- Reset values:
  - cell_o, cell_oe, cell_ie: 0 (pads tri-stated, inputs gated).
  - Synchronizers, stable bits, counters, IN, pend bits, IRQ_EN: 0.
  - DEBOUNCE: DEBOUNCE_RESET.
  - resp_valid, resp_rdata, irq: 0.
- Reset asserted mid-transaction drops any pending response. No response is issued after reset releases.

## Timing
- Register write to cell_o/oe/ie: visible after the accepting edge (1 cycle).
- Read response: 1 cycle after acceptance.
- Input latency, where cell_i settles before edge 0:
  - sync2 updates at edge 1.
  - With DEBOUNCE=N, stable, IN and the pend bit update at edge N+2.
  - irq is combinational from registers, so it rises after the same edge.
- A pulse on sync2 shorter than N+1 cycles is rejected.

## Configuration
- GPIO_PAD_CTRL_DEBOUNCE_EN defined: debounce counters and the DEBOUNCE register exist as above.
- GPIO_PAD_CTRL_DEBOUNCE_EN undefined:
  - No counters; stable <= sync2 every cycle, so latency is fixed at edge 2.
  - Address 7 reads 0 and ignores writes.
  - DEBOUNCE_W and DEBOUNCE_RESET are unused.

## Test plan
- Reset then read all 8 addresses -> all 0 except DEBOUNCE = DEBOUNCE_RESET; cell_oe = 0; irq = 0.
- Write OUT=0xA5 and OE=0x0F back-to-back with resp_ready=1 -> both accepted on consecutive cycles; cell_o=0xA5 and cell_oe=0x0F one cycle after each accept.
- Hold resp_ready=0 after a read of OUT -> resp_valid stays 1 with rdata=0xA5 and req_ready=0. Raise resp_ready -> the next request is accepted that cycle.
- DEBOUNCE=3, IRQ_EN=0x01, drive cell_i[0] high before edge 0 -> IN[0], RISE_PEND[0] and irq rise after edge 5. A 3-cycle pulse produces no edge.
- RISE_PEND[0]=1; write RISE_PEND=0x01 in the same cycle a new rise on bit 0 qualifies -> bit stays 1. A later W1C with no edge clears it and irq falls.
- Assert reset while resp_valid=1 and counters are mid-count -> all outputs 0 immediately. No response appears after release.
